// File: rtl/neopix_pkg.sv
// Shared types and constants for the ws2812 frame controller slice.
package neopix_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned G_MSB = 23;
  localparam int unsigned R_MSB = 15;
  localparam int unsigned B_MSB = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    SEND      = 2'd2
  } state_e;

endpackage

// File: rtl/neopix_pixel_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
module neopix_pixel_ram
  import neopix_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_data_q;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register updates only on request and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/neopix_frame_ctrl.sv
// Frame scheduler and double-buffered pixel store for the ws2812 driver.
module neopix_frame_ctrl
  import neopix_pkg::*;
#(
  parameter  int unsigned NUM_LEDS     = 256,
  parameter  int unsigned FRAME_PERIOD = 833333,
  parameter  int unsigned CNT_W        = 16,
  localparam int unsigned AW           = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [23:0]      wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  input  logic [8:0]       cfg_ledcount,
  output logic             drv_start,
  input  logic             drv_busy,
  input  logic             drv_data_request,
  input  logic [AW-1:0]    drv_address,
  output logic [7:0]       drv_red,
  output logic [7:0]       drv_green,
  output logic [7:0]       drv_blue,
  output logic [8:0]       drv_ledcount,
  output logic             frame_active,
  output logic [CNT_W-1:0] frame_count,
  output logic             overrun
);

  localparam int unsigned TW = $clog2(FRAME_PERIOD);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             frame_due_q, frame_due_d;
  logic             overrun_q, overrun_d;
  logic             swap_pend_q, swap_pend_d;
  logic             front_q, front_d;
  logic [8:0]       ledcount_q, ledcount_d;
  logic             frame_active_q, frame_active_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             tick;
  logic             launch;
  logic [PIX_W-1:0] rd_data;

  // Frame timer: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    tick    = enable && (timer_q == TW'(FRAME_PERIOD - 1));
    timer_d = timer_q + TW'(1);
    if (!enable || tick) begin
      timer_d = '0;
    end
  end

  // Frame-due flag and sticky overrun; a new tick wins over a same-cycle launch.
  always_comb begin
    overrun_d   = overrun_q | (tick & frame_due_q);
    frame_due_d = frame_due_q;
    if (tick) begin
      frame_due_d = 1'b1;
    end else if (launch) begin
      frame_due_d = 1'b0;
    end
  end

  // Frame sequencing FSM: launch, wait for driver to go busy, wait for it to finish.
  always_comb begin
    state_d        = state_q;
    front_d        = front_q;
    swap_pend_d    = swap_pend_q | swap_req;
    ledcount_d     = ledcount_q;
    frame_active_d = frame_active_q;
    frame_count_d  = frame_count_q;
    launch         = 1'b0;
    drv_start      = 1'b0;
    swap_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_due_q && enable && !drv_busy) begin
          launch    = 1'b1;
          drv_start = 1'b1;
          if (swap_pend_q) begin
            front_d     = ~front_q;
            swap_ack    = 1'b1;
            // A request landing on the swap cycle stays queued for the next boundary.
            swap_pend_d = swap_req;
          end
          ledcount_d     = cfg_ledcount;
          frame_active_d = 1'b1;
          state_d        = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (drv_busy) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!drv_busy) begin
          frame_count_d  = frame_count_q + CNT_W'(1);
          frame_active_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      frame_due_q    <= 1'b0;
      overrun_q      <= 1'b0;
      swap_pend_q    <= 1'b0;
      front_q        <= 1'b0;
      ledcount_q     <= '0;
      frame_active_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      frame_due_q    <= frame_due_d;
      overrun_q      <= overrun_d;
      swap_pend_q    <= swap_pend_d;
      front_q        <= front_d;
      ledcount_q     <= ledcount_d;
      frame_active_q <= frame_active_d;
      frame_count_q  <= frame_count_d;
    end
  end

  neopix_pixel_ram #(
    .DEPTH  (2 * NUM_LEDS),
    .ADDR_W (AW + 1)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i ({~front_q, wr_addr}),
    .wr_data_i (wr_data),
    .rd_en_i   (drv_data_request),
    .rd_addr_i ({front_q, drv_address}),
    .rd_data_o (rd_data)
  );

  assign drv_green    = rd_data[G_MSB -: 8];
  assign drv_red      = rd_data[R_MSB -: 8];
  assign drv_blue     = rd_data[B_MSB -: 8];
  assign drv_ledcount = ledcount_q;
  assign frame_active = frame_active_q;
  assign frame_count  = frame_count_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/neopix_frame_ctrl.md
Name: neopix_frame_ctrl

Overview:
Frame scheduler and pixel store for the ws2812 serial driver. Holds a double-buffered pixel RAM: the host/SPI side writes the back bank, and the driver reads the front bank. Issues one start pulse to the driver per frame period. Swaps banks only between frames, so a frame on the wire never mixes old and new pixels.

Parameters:
NUM_LEDS, 256, LEDs per bank; AW = $clog2(NUM_LEDS)
FRAME_PERIOD, 833333, clk cycles between frame starts (60 Hz at 50 MHz); min 16
CNT_W, 16, frame_count width

Ports:
clk  in  1  clock
reset  in  1  reset
enable  in  1  1 = frame timer runs and frames are issued
wr_en  in  1  host pixel write strobe
wr_addr  in  AW  back-bank pixel index
wr_data  in  24  {green[23:16], red[15:8], blue[7:0]}
swap_req  in  1  one-cycle pulse: publish back bank at next frame boundary
swap_ack  out  1  one-cycle pulse when the swap takes effect
cfg_ledcount  in  9  LED count for the next frame
drv_start  out  1  start pulse to driver
drv_busy  in  1  driver busy
drv_data_request  in  1  driver data request (rgb sampled next cycle)
drv_address  in  AW  driver current LED index
drv_red, drv_green, drv_blue  out  8 each  pixel to driver
drv_ledcount  out  9  ledcount to driver, stable for a whole frame
frame_active  out  1  high from drv_start until driver returns idle
frame_count  out  CNT_W  completed frames, wraps
overrun  out  1  sticky: a frame tick arrived while the previous one was still pending

Behaviour:
- Reset is synchronous and active-high, on clk; it applies mid-frame too. Reset values: all outputs 0; front bank = 0; state IDLE; timer = 0; frame_due = 0; swap_pend = 0. RAM contents are not cleared.
- Timer: counts 0..FRAME_PERIOD-1 while enable=1, and holds at 0 while enable=0. At terminal count it produces a one-cycle tick. A tick sets frame_due. If frame_due is already 1 when a tick arrives, overrun <= 1 (cleared only by reset).
- swap_req sets swap_pend. A swap_req arriving in the same cycle as the swap is applied remains pending for the next boundary.
- Host write: when wr_en=1, RAM[{~front, wr_addr}] <= wr_data. Writes are accepted every cycle and never stall. An out-of-range wr_addr wraps modulo 2^AW.
- Read: when drv_data_request=1, RAM[{front, drv_address}] is read. drv_green/red/blue are registered exactly 1 cycle later and held until the next request. front does not change between the request and the output update.
- FSM:
  - IDLE: if frame_due && !drv_busy:
    - if swap_pend: front <= ~front; swap_ack=1; swap_pend <= 0.
    - drv_ledcount <= cfg_ledcount.
    - drv_start=1 for exactly 1 cycle; frame_due <= 0; frame_active <= 1.
    - -> WAIT_BUSY.
  - WAIT_BUSY: wait for drv_busy=1 (unbounded; the driver may still be finishing its reset interval). -> SEND.
  - SEND: on drv_busy falling to 0: frame_count += 1; frame_active <= 0. -> IDLE.
- A new start is issued no earlier than the cycle after returning to IDLE. Minimum spacing between two drv_start pulses is 3 cycles.
- enable dropped mid-frame: the current frame completes; no further starts are issued; a pending frame_due is kept.
- cfg_ledcount changes mid-frame have no effect until the next start.

Decomposition:
- Package neopix_pkg holds:
  - FSM state encoding (IDLE, WAIT_BUSY, SEND);
  - pixel byte-field constants (G_MSB=23, R_MSB=15, B_MSB=7);
  - the PIX_W=24 constant.
- One sub-module, neopix_pixel_ram: simple dual-port, 2*NUM_LEDS x 24, one write port, one registered read port, synchronous.

Test Plan:
- Write back-bank addr 3 = 0x12_34_56, pulse swap_req, let a frame run; on request for address 3 -> next cycle drv_green=0x12, drv_red=0x34, drv_blue=0x56, and swap_ack coincides with drv_start.
- FRAME_PERIOD=200, driver model busy for 50 cycles -> drv_start every 200 cycles, frame_count 0->1->2->3, overrun stays 0.
- FRAME_PERIOD=200, driver model busy for 450 cycles -> overrun=1 after the second tick; starts spaced >=450 cycles.
- Host writes front-index values during SEND without a swap -> driver output unchanged: all reads return the previous front data.
- reset asserted in SEND -> next cycle all outputs 0, front=0, state IDLE; first start occurs FRAME_PERIOD cycles after reset release.
- cfg_ledcount changed 8->4 mid-frame -> drv_ledcount stays 8 until the next drv_start, then becomes 4.
